executor_rotate_kick: RTL

Rotation executor with wall-kick for the Tetris game core. On a rotate request it latches the active tile's type, angle and position, computes the target angle (clockwise or counter-clockwise), then walks a parametrised list of horizontal kick offsets. For each candidate it asks the collision checker whether the rotated tile fits, and commits the first fitting pose to the current-state memory. Sits between the command decoder and the current-state memory/collision checker, replacing the fixed no-kick rotate executor.

---
 rtl/executor_rotate_kick_pkg.sv | 47 ++++
 rtl/executor_rotate_kick_candidate.sv | 31 +++
 rtl/executor_rotate_kick.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/executor_rotate_kick_pkg.sv
// Shared types for the rotate-with-kick executor: tile types, FSM states and
// the horizontal kick offset table.
// Kick k maps to dx = 0, -1, +1, -2, +2; y never changes during a kick.
package executor_rotate_kick_pkg;

    typedef enum logic [2:0] {
        eI   = 3'd0,
        eO   = 3'd1,
        eT   = 3'd2,
        eS   = 3'd3,
        eZ   = 3'd4,
        eJ   = 3'd5,
        eL   = 3'd6,
        eNon = 3'd7
    } tile_type_e;

    typedef enum logic [2:0] {
        eIDLE    = 3'd0,
        eQuery   = 3'd1,
        eResp    = 3'd2,
        eWrite   = 3'd3,
        eWaiting = 3'd4,
        eDone    = 3'd5
    } rot_state_e;

    localparam int KICK_OFF_W = 3;
    localparam int KICK_MAX   = 5;

    // Entry k lives at bits [k*KICK_OFF_W +: KICK_OFF_W], two's complement.
    localparam logic [KICK_MAX*KICK_OFF_W-1:0] KICK_TABLE = {
        3'b010,   // k=4 : +2
        3'b110,   // k=3 : -2
        3'b001,   // k=2 : +1
        3'b111,   // k=1 : -1
        3'b000    // k=0 :  0
    };

    function automatic logic signed [KICK_OFF_W-1:0] kick_dx(input logic [2:0] k);
        int idx;
        idx = int'(k);
        if (idx < KICK_MAX) begin
            return signed'(KICK_TABLE[idx*KICK_OFF_W +: KICK_OFF_W]);
        end
        return '0;
    endfunction

endpackage

// File: rtl/executor_rotate_kick_candidate.sv
// Purpose: kick candidate x = x + dx[k] plus a board-bounds/kick-range check.
// Ports:   x_i, k_i in; cand_x_o (truncated to XW) and cand_ok_o out.
// Purely combinational; the add is done in XW+2 signed bits so a -2 kick from
// x=0 shows up as negative rather than wrapping to the far edge.
module rotate_kick_candidate
    import executor_rotate_kick_pkg::*;
#(
    parameter int width_p      = 16,
    parameter int kick_count_p = 5
) (
    input  logic [$clog2(width_p)-1:0] x_i,
    input  logic [2:0]                 k_i,
    output logic [$clog2(width_p)-1:0] cand_x_o,
    output logic                       cand_ok_o
);
    localparam int XW = $clog2(width_p);

    logic signed [KICK_OFF_W-1:0] dx;
    logic signed [XW+1:0]         sum;

    assign dx  = kick_dx(k_i);
    assign sum = $signed({2'b00, x_i})
               + $signed({{(XW+2-KICK_OFF_W){dx[KICK_OFF_W-1]}}, dx});

    assign cand_x_o  = sum[XW-1:0];
    // Non-negative, below the board width, and a kick index that is in use.
    assign cand_ok_o = !sum[XW+1]
                    && (sum[XW:0] < (XW+1)'(width_p))
                    && (32'(k_i) < kick_count_p);

endmodule

// File: rtl/executor_rotate_kick.sv
// Purpose: rotate the active tile, trying horizontal kicks until the collision
//          checker reports a fit, then commit the pose to current-state memory.
// Ports:   v_i/dir_i/type_i/angle_i/x_i/y_i request; query_* + resp_* to the
//          collision checker; set_v_o/type_o..y_o + cm_is_ready_i to memory;
//          done_o/success_o completion. Outputs type_o..y_o are registered.
module executor_rotate_kick
    import executor_rotate_kick_pkg::*;
#(
    parameter int width_p      = 16,
    parameter int height_p     = 32,
    parameter int kick_count_p = 5
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          v_i,
    input  logic                          dir_i,
    input  tile_type_e                    type_i,
    input  logic [1:0]                    angle_i,
    input  logic [$clog2(width_p)-1:0]    x_i,
    input  logic [$clog2(height_p)-1:0]   y_i,
    output logic                          query_v_o,
    input  logic                          query_ready_i,
    output tile_type_e                    query_type_o,
    output logic [1:0]                    query_angle_o,
    output logic [$clog2(width_p)-1:0]    query_x_o,
    output logic [$clog2(height_p)-1:0]   query_y_o,
    input  logic                          resp_v_i,
    input  logic                          resp_hit_i,
    input  logic                          cm_is_ready_i,
    output logic                          set_v_o,
    output tile_type_e                    type_o,
    output logic [1:0]                    angle_o,
    output logic [$clog2(width_p)-1:0]    x_o,
    output logic [$clog2(height_p)-1:0]   y_o,
    output logic                          done_o,
    output logic                          success_o
);
    localparam int XW = $clog2(width_p);
    localparam int YW = $clog2(height_p);

    rot_state_e    state_q, state_d;
    tile_type_e    type_q, type_d;
    logic [1:0]    angle_q, angle_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [2:0]    k_q, k_d;
    logic          trivial_q, trivial_d;
    logic          success_q, success_d;
    tile_type_e    otype_q, otype_d;
    logic [1:0]    oangle_q, oangle_d;
    logic [XW-1:0] ox_q, ox_d;
    logic [YW-1:0] oy_q, oy_d;

    logic [XW-1:0] cand_x;
    logic          cand_ok;
    logic          last_kick;

    rotate_kick_candidate #(
        .width_p      (width_p),
        .kick_count_p (kick_count_p)
    ) u_cand (
        .x_i       (x_q),
        .k_i       (k_q),
        .cand_x_o  (cand_x),
        .cand_ok_o (cand_ok)
    );

    assign last_kick = (k_q == 3'(kick_count_p - 1));

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= eIDLE;
            type_q    <= eNon;
            angle_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            k_q       <= '0;
            trivial_q <= 1'b0;
            success_q <= 1'b0;
            otype_q   <= eNon;
            oangle_q  <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            angle_q   <= angle_d;
            x_q       <= x_d;
            y_q       <= y_d;
            k_q       <= k_d;
            trivial_q <= trivial_d;
            success_q <= success_d;
            otype_q   <= otype_d;
            oangle_q  <= oangle_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        angle_d   = angle_q;
        x_d       = x_q;
        y_d       = y_q;
        k_d       = k_q;
        trivial_d = trivial_q;
        success_d = success_q;
        otype_d   = otype_q;
        oangle_d  = oangle_q;
        ox_d      = ox_q;
        oy_d      = oy_q;

        unique case (state_q)
            eIDLE: begin
                if (v_i) begin
                    type_d    = type_i;
                    x_d       = x_i;
                    y_d       = y_i;
                    angle_d   = dir_i ? (angle_i - 2'd1) : (angle_i + 2'd1);
                    k_d       = '0;
                    // O is rotation-invariant (trivially succeeds); Non has
                    // nothing to rotate. Both skip the checker entirely.
                    trivial_d = (type_i == eO) || (type_i == eNon);
                    success_d = (type_i == eO);
                    state_d   = eQuery;
                end
            end
            eQuery: begin
                if (trivial_q) begin
                    // One idle pass through eQuery with the query suppressed
                    // gives O/Non their two-cycle completion latency.
                    state_d = eDone;
                end else if (!cand_ok) begin
                    if (last_kick) begin
                        success_d = 1'b0;
                        state_d   = eDone;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end else if (query_ready_i) begin
                    state_d = eResp;
                end
            end
            eResp: begin
                if (resp_v_i) begin
                    if (!resp_hit_i) begin
                        otype_d  = type_q;
                        oangle_d = angle_q;
                        ox_d     = cand_x;
                        oy_d     = y_q;
                        state_d  = eWrite;
                    end else if (last_kick) begin
                        success_d = 1'b0;
                        state_d   = eDone;
                    end else begin
                        k_d     = k_q + 3'd1;
                        state_d = eQuery;
                    end
                end
            end
            eWrite: begin
                state_d = eWaiting;
            end
            eWaiting: begin
                if (cm_is_ready_i) begin
                    success_d = 1'b1;
                    state_d   = eDone;
                end
            end
            eDone: begin
                state_d = eIDLE;
            end
            default: begin
                state_d = eIDLE;
            end
        endcase
    end

    assign query_v_o     = (state_q == eQuery) && !trivial_q && cand_ok;
    assign query_type_o  = type_q;
    assign query_angle_o = angle_q;
    assign query_x_o     = cand_x;
    assign query_y_o     = y_q;

    assign set_v_o   = (state_q == eWrite);
    assign done_o    = (state_q == eDone);
    assign success_o = (state_q == eDone) && success_q;

    assign type_o  = otype_q;
    assign angle_o = oangle_q;
    assign x_o     = ox_q;
    assign y_o     = oy_q;

endmodule
